// File: rtl/uart_pkg.sv
// Shared UART definitions: default FIFO depth, RX entry layout, trigger levels.
package uart_pkg;

    localparam int unsigned DEPTH_DEFAULT = 16;

    // One receive FIFO entry: character plus the error flags that came with it.
    typedef struct packed {
        logic       bi;
        logic       fe;
        logic       pe;
        logic [7:0] data;
    } rx_entry_t;

    // FCR[7:6] receive trigger-level encoding.
    typedef enum logic [1:0] {
        TRIG_1  = 2'b00,
        TRIG_4  = 2'b01,
        TRIG_8  = 2'b10,
        TRIG_14 = 2'b11
    } rx_trig_e;

    // Number of entries needed to raise the receive-data-available condition.
    function automatic logic [4:0] trig_level(input logic [1:0] thr);
        case (rx_trig_e'(thr))
            TRIG_1:  return 5'd1;
            TRIG_4:  return 5'd4;
            TRIG_8:  return 5'd8;
            default: return 5'd14;
        endcase
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-array FIFO storage: synchronous write, asynchronous read.
module uart_fifo_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4,
    parameter int unsigned W     = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Write port; contents need no reset since reads are masked while empty.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// 16550-style receive FIFO with trigger level, overrun and error-in-FIFO status.
// Optional macro RX_FIFO_ERR_TRACK_EN: store per-entry pe/fe/bi and build errcnt.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fifo_en,
    input  logic          clr,
    input  logic [1:0]    thr,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pe_in,
    input  logic          fe_in,
    input  logic          bi_in,
    input  logic          pop,
    input  logic          ovr_clr,
    output logic [7:0]    dout,
    output logic          dout_pe,
    output logic          dout_fe,
    output logic          dout_bi,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full,
    output logic          trig,
    output logic          overrun,
    output logic          err_in_fifo
);

`ifdef RX_FIFO_ERR_TRACK_EN
    localparam int unsigned EW = 11;
`else
    localparam int unsigned EW = 8;
`endif

    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;
    logic          fifo_en_q;
    logic [AW:0]   cap;
    logic          flush;
    logic          do_push;
    logic          do_pop;
    logic          ovf;
    logic [EW-1:0] wdata;
    logic [EW-1:0] rdata;

    // Capacity follows the registered mode so it only changes together with a flush.
    assign cap     = fifo_en_q ? (AW+1)'(DEPTH) : (AW+1)'(1);
    assign empty   = (cnt == '0);
    assign full    = (cnt == cap);
    assign count   = cnt;
    assign flush   = clr || (fifo_en != fifo_en_q);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);
    assign ovf     = push && !flush && full && !do_pop;
    assign trig    = fifo_en_q ? (32'(cnt) >= 32'(trig_level(thr))) : !empty;

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (EW)
    ) u_mem (
        .clk   (clk),
        .we    (do_push),
        .waddr (wp),
        .wdata (wdata),
        .raddr (rp),
        .rdata (rdata)
    );

    // Pointers, occupancy, mode tracking and sticky overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp        <= '0;
            rp        <= '0;
            cnt       <= '0;
            fifo_en_q <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            fifo_en_q <= fifo_en;
            if (flush) begin
                wp  <= '0;
                rp  <= '0;
                cnt <= '0;
            end else begin
                if (do_push) wp <= wp + AW'(1);
                if (do_pop)  rp <= rp + AW'(1);
                if (do_push && !do_pop) cnt <= cnt + (AW+1)'(1);
                else if (do_pop && !do_push) cnt <= cnt - (AW+1)'(1);
            end
            if (ovf) overrun <= 1'b1;
            else if (ovr_clr) overrun <= 1'b0;
        end
    end

`ifdef RX_FIFO_ERR_TRACK_EN
    rx_entry_t   wr_ent;
    rx_entry_t   hd_ent;
    logic [AW:0] errcnt;
    logic        push_err;
    logic        pop_err;

    assign wr_ent   = '{bi: bi_in, fe: fe_in, pe: pe_in, data: din};
    assign wdata    = wr_ent;
    assign hd_ent   = rdata;
    assign push_err = do_push && (pe_in || fe_in || bi_in);
    assign pop_err  = do_pop && (hd_ent.pe || hd_ent.fe || hd_ent.bi);

    assign dout        = empty ? 8'h00 : hd_ent.data;
    assign dout_pe     = !empty && hd_ent.pe;
    assign dout_fe     = !empty && hd_ent.fe;
    assign dout_bi     = !empty && hd_ent.bi;
    assign err_in_fifo = (errcnt != '0);

    // Number of stored entries carrying any error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            errcnt <= '0;
        end else if (flush) begin
            errcnt <= '0;
        end else if (push_err && !pop_err) begin
            errcnt <= errcnt + (AW+1)'(1);
        end else if (pop_err && !push_err) begin
            errcnt <= errcnt - (AW+1)'(1);
        end
    end
`else
    logic unused_err_flags;

    assign unused_err_flags = pe_in ^ fe_in ^ bi_in;
    assign wdata            = din;
    assign dout             = empty ? 8'h00 : rdata;
    assign dout_pe          = 1'b0;
    assign dout_fe          = 1'b0;
    assign dout_bi          = 1'b0;
    assign err_in_fifo      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: vector table, directed corner sequences, random vs queue model.
module tb_uart_rx_fifo;

`ifdef RX_FIFO_ERR_TRACK_EN
    localparam bit TRACK = 1'b1;
`else
    localparam bit TRACK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       fifo_en, clr, push, pe_in, fe_in, bi_in, pop, ovr_clr;
    logic [1:0] thr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       dout_pe, dout_fe, dout_bi;
    logic [4:0] count;
    logic       empty, full, trig, overrun, err_in_fifo;

    int checks   = 0;
    int failures = 0;

    // Reference model: queue of {bi,fe,pe,data}, current mode, sticky overrun.
    logic [10:0] mq[$];
    bit          m_mode;
    bit          m_ovr;

    uart_rx_fifo dut (
        .clk (clk), .rst (rst), .fifo_en (fifo_en), .clr (clr), .thr (thr),
        .push (push), .din (din), .pe_in (pe_in), .fe_in (fe_in), .bi_in (bi_in),
        .pop (pop), .ovr_clr (ovr_clr), .dout (dout), .dout_pe (dout_pe),
        .dout_fe (dout_fe), .dout_bi (dout_bi), .count (count), .empty (empty),
        .full (full), .trig (trig), .overrun (overrun), .err_in_fifo (err_in_fifo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [20:0] dut_status();
        return {count, empty, full, trig, overrun, err_in_fifo, dout_bi, dout_fe, dout_pe, dout};
    endfunction

    function automatic int level_of(input logic [1:0] t);
        int lv[4] = '{1, 4, 8, 14};
        return lv[t];
    endfunction

    function automatic logic [20:0] model_status();
        int    n   = mq.size();
        int    cap = m_mode ? 16 : 1;
        bit    tr  = m_mode ? (n >= level_of(thr)) : (n != 0);
        bit    er  = 1'b0;
        logic [10:0] hd = (n != 0) ? mq[0] : 11'h0;
        foreach (mq[i]) if (mq[i][10:8] != 3'b000) er = 1'b1;
        if (!TRACK) begin
            er = 1'b0;
            hd[10:8] = 3'b000;
        end
        return {5'(n), n == 0, n == cap, tr, m_ovr, er, hd};
    endfunction

    // Apply one model clock edge from the spec's rules.
    task automatic model_step(input bit en, input bit c, input bit pu, input bit po,
                              input bit oc, input logic [10:0] ent);
        bit flush, had, was_full, popped, ovf;
        flush = c || (en != m_mode);
        ovf   = 1'b0;
        if (flush) begin
            mq.delete();
        end else begin
            had      = mq.size() != 0;
            was_full = mq.size() == (m_mode ? 16 : 1);
            popped   = po && had;
            if (popped) void'(mq.pop_front());
            if (pu) begin
                if (!was_full || popped) mq.push_back(ent);
                else ovf = 1'b1;
            end
        end
        if (ovf) m_ovr = 1'b1;
        else if (oc) m_ovr = 1'b0;
        m_mode = en;
    endtask

    task automatic model_reset();
        mq.delete();
        m_mode = 1'b0;
        m_ovr  = 1'b0;
    endtask

    // Drive one cycle of inputs, clock it, step model, return at the next falling edge.
    task automatic cycle(input bit en, input bit c, input logic [1:0] t, input bit pu,
                         input logic [7:0] d, input bit pe, input bit fe, input bit bi,
                         input bit po, input bit oc);
        fifo_en = en; clr = c; thr = t; push = pu; din = d;
        pe_in = pe; fe_in = fe; bi_in = bi; pop = po; ovr_clr = oc;
        @(posedge clk);
        model_step(en, c, pu, po, oc, {bi, fe, pe, d});
        @(negedge clk);
    endtask

    typedef struct {
        bit         en, clr;
        logic [1:0] thr;
        bit         push;
        logic [7:0] din;
        bit         fe, pop, oc;
        int         cnt;
        bit         emp, ful, trg, ovr, err;
        logic [7:0] dout;
    } vec_t;

    vec_t tbl[16];

    initial begin
        tbl[0]  = '{1,0,2'd0,0,8'h00,0,0,0, 0,1,0,0,0,0,8'h00};
        tbl[1]  = '{1,0,2'd0,1,8'h45,0,0,0, 1,0,0,1,0,0,8'h45};
        tbl[2]  = '{1,0,2'd0,0,8'h00,0,1,0, 0,1,0,0,0,0,8'h00};
        tbl[3]  = '{1,0,2'd0,1,8'h11,1,0,0, 1,0,0,1,0,1,8'h11};
        tbl[4]  = '{1,0,2'd0,1,8'h22,0,0,0, 2,0,0,1,0,1,8'h11};
        tbl[5]  = '{1,0,2'd0,0,8'h00,0,1,0, 1,0,0,1,0,0,8'h22};
        tbl[6]  = '{1,0,2'd0,1,8'h33,0,1,0, 1,0,0,1,0,0,8'h33};
        tbl[7]  = '{1,0,2'd0,0,8'h00,0,1,0, 0,1,0,0,0,0,8'h00};
        tbl[8]  = '{1,0,2'd0,1,8'h44,0,1,0, 1,0,0,1,0,0,8'h44};
        tbl[9]  = '{1,1,2'd0,1,8'h55,0,0,0, 0,1,0,0,0,0,8'h00};
        tbl[10] = '{0,0,2'd0,1,8'h01,0,0,0, 0,1,0,0,0,0,8'h00};
        tbl[11] = '{0,0,2'd0,1,8'h01,0,0,0, 1,0,1,1,0,0,8'h01};
        tbl[12] = '{0,0,2'd0,1,8'h02,0,0,0, 1,0,1,1,1,0,8'h01};
        tbl[13] = '{1,0,2'd0,0,8'h00,0,0,0, 0,1,0,0,1,0,8'h00};
        tbl[14] = '{1,0,2'd0,1,8'h03,0,0,1, 1,0,0,1,0,0,8'h03};
        tbl[15] = '{1,0,2'd0,0,8'h00,0,1,0, 0,1,0,0,0,0,8'h00};

        rst = 1'b1; fifo_en = 1'b1; clr = 1'b0; thr = 2'd0; push = 1'b0; din = 8'h00;
        pe_in = 1'b0; fe_in = 1'b0; bi_in = 1'b0; pop = 1'b0; ovr_clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_state", 32'(dut_status()), {11'h0, 5'd0, 5'b10000, 11'h0});
        rst = 1'b0;

        // Vector table: basic push/pop, errors, clr, 16450 mode, mode toggle.
        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].en, tbl[i].clr, tbl[i].thr, tbl[i].push, tbl[i].din,
                  1'b0, tbl[i].fe, 1'b0, tbl[i].pop, tbl[i].oc);
            check($sformatf("vec%0d", i),
                  {14'h0, count, empty, full, trig, overrun, err_in_fifo, dout},
                  {14'h0, 5'(tbl[i].cnt), tbl[i].emp, tbl[i].ful, tbl[i].trg, tbl[i].ovr,
                   TRACK & tbl[i].err, tbl[i].dout});
        end

        // Fill to 16 with threshold 14, then overflow.
        for (int k = 1; k <= 16; k++) begin
            cycle(1, 0, 2'd3, 1, 8'(k - 1), 0, 0, 0, 0, 0);
            if (k == 13 || k == 14) check($sformatf("trig_at_%0d", k), 32'(trig), 32'(k >= 14));
            if (k == 15 || k == 16) check($sformatf("full_at_%0d", k), 32'(full), 32'(k == 16));
        end
        cycle(1, 0, 2'd3, 1, 8'hAA, 0, 0, 0, 0, 0);
        check("ovf_overrun", 32'(overrun), 32'd1);
        check("ovf_count", 32'(count), 32'd16);
        check("ovf_head", 32'(dout), 32'h00);
        cycle(1, 0, 2'd3, 0, 8'h00, 0, 0, 0, 0, 1);
        check("ovr_clr", 32'(overrun), 32'd0);

        // Full with simultaneous push and pop.
        cycle(1, 0, 2'd3, 1, 8'hBB, 0, 0, 0, 1, 0);
        check("full_pushpop", {26'h0, count, overrun}, {26'h0, 5'd16, 1'b0});
        for (int k = 1; k <= 16; k++) begin
            check($sformatf("drain_%0d", k), 32'(dout), (k == 16) ? 32'hBB : 32'(k));
            cycle(1, 0, 2'd3, 0, 8'h00, 0, 0, 0, 1, 0);
        end
        check("drained_empty", 32'(empty), 32'd1);

        // Empty with simultaneous push and pop.
        cycle(1, 0, 2'd0, 1, 8'h5A, 0, 0, 0, 1, 0);
        check("empty_pushpop", {24'h0, count, 3'b0}, {24'h0, 5'd1, 3'b0});
        check("empty_pushpop_head", 32'(dout), 32'h5A);

        // Reset asserted mid-sequence.
        for (int k = 0; k < 5; k++) cycle(1, 0, 2'd1, 1, 8'(8'h60 + k), 0, 1, 0, 0, 0);
        cycle(1, 0, 2'd1, 1, 8'h70, 0, 0, 0, 0, 0);
        check("pre_reset_model", 32'(dut_status()), 32'(model_status()));
        #2 rst = 1'b1;
        #1 check("mid_reset", 32'(dut_status()), {11'h0, 5'd0, 5'b10000, 11'h0});
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic against the queue model.
        for (int n = 0; n < 3000; n++) begin
            bit en_r = fifo_en;
            if ($urandom_range(0, 199) == 0) en_r = ~en_r;
            cycle(en_r, $urandom_range(0, 99) < 2, 2'($urandom),
                  $urandom_range(0, 99) < 55, 8'($urandom),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 99) < 45, $urandom_range(0, 9) == 0);
            check($sformatf("rand%0d", n), 32'(dut_status()), 32'(model_status()));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
